// File: rtl/univ_shift_seq_pkg.sv
// Shared definitions for the universal shift register: op codes, FSM states
// and the reserved-op predicate.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic logic is_reserved_op(input logic [2:0] op);
        return op > 3'(OP_ROR);
    endfunction

endpackage

// File: rtl/univ_shift_seq_step_mux.sv
// Single-step shift datapath: per-bit mux choosing the left or right
// neighbour (with fill bit) according to the operation.
module shift_step_mux
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] o,
    input  logic [2:0]       op,
    input  logic             IL,
    input  logic             IR,
    output logic [WIDTH-1:0] nxt,
    output logic             so
);

    localparam int M = WIDTH - 1;

    logic             lsb_fill;
    logic             msb_fill;
    logic             go_left;
    logic             go_right;
    logic [WIDTH-1:0] from_below;
    logic [WIDTH-1:0] from_above;

    always_comb begin
        lsb_fill = IR;
        msb_fill = IL;
        go_left  = 1'b0;
        go_right = 1'b0;
        so       = 1'b0;
        case (op)
            OP_SLL: begin go_left  = 1'b1; lsb_fill = IR;   so = o[M]; end
            OP_ROL: begin go_left  = 1'b1; lsb_fill = o[M]; so = o[M]; end
            OP_SRL: begin go_right = 1'b1; msb_fill = IL;   so = o[0]; end
            OP_SRA: begin go_right = 1'b1; msb_fill = o[M]; so = o[0]; end
            OP_ROR: begin go_right = 1'b1; msb_fill = o[0]; so = o[0]; end
            default: ;
        endcase
    end

    // Neighbour vectors: bit i of from_below is o[i-1], of from_above is o[i+1].
    assign from_below = {o[M-1:0], lsb_fill};
    assign from_above = {msb_fill, o[M:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign nxt[i] = go_left  ? from_below[i] :
                        go_right ? from_above[i] : o[i];
    end

endmodule

// File: rtl/univ_shift_seq.sv
// Universal shift register with start/busy/done sequencing; performs one
// single-bit shift step per clock for the requested amount.
module univ_shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] In,
    input  logic             IL,
    input  logic             IR,
    input  logic             load,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] out,
    output logic             so,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] step_word;
    logic             step_so;

    shift_step_mux #(.WIDTH(WIDTH)) u_mux (
        .o   (out),
        .op  (op_q),
        .IL  (IL),
        .IR  (IR),
        .nxt (step_word),
        .so  (step_so)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            out   <= '0;
            so    <= 1'b0;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        out <= In;
                    end else if (start) begin
                        op_q <= op;
                        cnt  <= amt;
                    end
                end
                ST_SHIFT: begin
                    out <= step_word;
                    so  <= step_so;
                    cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!load && start) begin
                    // Zero-length and reserved requests skip straight to completion.
                    if (amt == '0 || is_reserved_op(op))
                        state_nxt = ST_DONE;
                    else
                        state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt == AW'(1))
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                err       = is_reserved_op(op_q);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_univ_shift_seq.sv
// Directed self-checking bench for univ_shift_seq (WIDTH=8).
module tb_univ_shift_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] In;
    logic       IL, IR, load, start;
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] out;
    logic       so, busy, done, err;

    int errors = 0;
    int checks = 0;

    univ_shift_seq #(.WIDTH(8), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .In    (In),
        .IL    (IL),
        .IR    (IR),
        .load  (load),
        .start (start),
        .op    (op),
        .amt   (amt),
        .out   (out),
        .so    (so),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic b, input logic d, input logic e);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".err"},  32'(err),  32'(e));
    endtask

    task automatic do_load(input logic [7:0] v);
        In = v; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] o, input logic [3:0] a);
        op = o; amt = a; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; In = '0; IL = 1'b0; IR = 1'b0;
        load = 1'b0; start = 1'b0; op = '0; amt = '0;
        #2;
        chk("rst.out", 32'(out), 32'h00);
        chk("rst.so", 32'(so), 32'h0);
        chk_ctl("rst", 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        // 1: SLL by 3 with IR=1
        do_load(8'hA5);
        chk("t1.load", 32'(out), 32'hA5);
        IR = 1'b1;
        do_start(3'b000, 4'd3);
        chk_ctl("t1.k", 1'b1, 1'b0, 1'b0);
        chk("t1.k.out", 32'(out), 32'hA5);
        tick();
        chk("t1.s1", 32'(out), 32'h4B); chk("t1.so1", 32'(so), 32'h1);
        chk("t1.s1.busy", 32'(busy), 32'h1);
        tick();
        chk("t1.s2", 32'(out), 32'h97); chk("t1.so2", 32'(so), 32'h0);
        chk("t1.s2.busy", 32'(busy), 32'h1);
        tick();
        chk("t1.s3", 32'(out), 32'h2F); chk("t1.so3", 32'(so), 32'h1);
        chk_ctl("t1.done", 1'b0, 1'b1, 1'b0);
        tick();
        chk_ctl("t1.after", 1'b0, 1'b0, 1'b0);
        chk("t1.hold", 32'(out), 32'h2F);
        IR = 1'b0;

        // 2: SRA by 2
        do_load(8'h90);
        do_start(3'b010, 4'd2);
        tick();
        chk("t2.s1", 32'(out), 32'hC8); chk("t2.so1", 32'(so), 32'h0);
        tick();
        chk("t2.s2", 32'(out), 32'hE4); chk("t2.so2", 32'(so), 32'h0);
        chk_ctl("t2.done", 1'b0, 1'b1, 1'b0);
        tick();

        // 3: ROR by 9 wraps past the width; ROL by 8 is identity
        do_load(8'h81);
        do_start(3'b100, 4'd9);
        for (int i = 0; i < 8; i++) tick();
        chk("t3.ror8", 32'(out), 32'h81);
        chk("t3.ror8.busy", 32'(busy), 32'h1);
        tick();
        chk("t3.ror9", 32'(out), 32'hC0); chk("t3.so", 32'(so), 32'h1);
        chk_ctl("t3.done", 1'b0, 1'b1, 1'b0);
        tick();
        do_load(8'h3C);
        do_start(3'b011, 4'd8);
        for (int i = 0; i < 8; i++) tick();
        chk("t3.rol8", 32'(out), 32'h3C);
        chk_ctl("t3.rol.done", 1'b0, 1'b1, 1'b0);
        tick();

        // 4: zero amount, then a reserved op
        do_start(3'b000, 4'd0);
        chk_ctl("t4.amt0", 1'b0, 1'b1, 1'b0);
        chk("t4.amt0.out", 32'(out), 32'h3C);
        tick();
        chk_ctl("t4.idle", 1'b0, 1'b0, 1'b0);
        do_start(3'b110, 4'd5);
        chk_ctl("t4.rsv", 1'b0, 1'b1, 1'b1);
        chk("t4.rsv.out", 32'(out), 32'h3C);
        tick();
        chk_ctl("t4.rsv.after", 1'b0, 1'b0, 1'b0);

        // 5: load beats start; start during SHIFT ignored
        In = 8'h55; load = 1'b1; start = 1'b1; op = 3'b000; amt = 4'd2;
        tick();
        load = 1'b0; start = 1'b0;
        chk("t5.ls.out", 32'(out), 32'h55);
        chk_ctl("t5.ls", 1'b0, 1'b0, 1'b0);
        tick();
        chk_ctl("t5.ls2", 1'b0, 1'b0, 1'b0);
        do_start(3'b000, 4'd4);
        tick();
        chk("t5.s1", 32'(out), 32'hAA);
        op = 3'b001; amt = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5.s2", 32'(out), 32'h54);
        tick();
        chk("t5.s3", 32'(out), 32'hA8);
        chk("t5.s3.busy", 32'(busy), 32'h1);
        tick();
        chk("t5.s4", 32'(out), 32'h50);
        chk_ctl("t5.done", 1'b0, 1'b1, 1'b0);
        tick();

        // 6: async reset mid-SRL
        do_load(8'hF0);
        IL = 1'b1;
        do_start(3'b001, 4'd6);
        tick();
        tick();
        chk("t6.pre", 32'(out), 32'hFC);
        #2 reset = 1'b0;
        #1;
        chk("t6.rst.out", 32'(out), 32'h00);
        chk("t6.rst.so", 32'(so), 32'h0);
        chk_ctl("t6.rst", 1'b0, 1'b0, 1'b0);
        #3 reset = 1'b1;
        tick();
        chk_ctl("t6.idle", 1'b0, 1'b0, 1'b0);
        chk("t6.idle.out", 32'(out), 32'h00);
        do_load(8'h3C);
        chk("t6.load", 32'(out), 32'h3C);
        chk_ctl("t6.load", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
